// File: rtl/arb_pkg.sv
// Shared types and constants for the three-way round-robin arbiter.
package arb_pkg;

  localparam int NUM_REQ = 3;
  localparam logic [1:0] OWNER_NONE = 2'd3;

  typedef logic [1:0] arb_idx_t;

  typedef enum logic {
    ST_IDLE,
    ST_OWNED
  } arb_state_t;

  function automatic arb_idx_t next_idx(input arb_idx_t i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational rotate search: first active request in order start, start+1, start+2 (mod 3).
module rr_pick3
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  arb_idx_t           start,
  output logic [NUM_REQ-1:0] gnt,
  output arb_idx_t           idx
);

  arb_idx_t w_c0;
  arb_idx_t w_c1;
  arb_idx_t w_c2;

  assign w_c0 = start;
  assign w_c1 = next_idx(start);
  assign w_c2 = next_idx(w_c1);

  always_comb begin
    gnt = '0;
    idx = OWNER_NONE;
    if (req[w_c0])      idx = w_c0;
    else if (req[w_c1]) idx = w_c1;
    else if (req[w_c2]) idx = w_c2;
    if (idx != OWNER_NONE) gnt = 3'b001 << idx;
  end

endmodule

// File: rtl/rr_arbiter3.sv
// Three-requester round-robin arbiter with sticky ownership and optional bounded-hold preemption.
// state    | meaning
// ST_IDLE  | owner = none, next grant comes from the rotate search
// ST_OWNED | owner = k, k keeps the grant while requesting and not expired
module rr_arbiter3
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       r1,
  input  logic       r2,
  input  logic       r3,
  output logic       g1,
  output logic       g2,
  output logic       g3,
  output logic [1:0] gid
);

  localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

  arb_idx_t          r_owner;
  arb_idx_t          r_ptr;
  logic [HW-1:0]     r_hold_cnt;

  arb_idx_t          w_owner_nxt;
  arb_idx_t          w_ptr_nxt;
  logic [HW-1:0]     w_hold_nxt;

  arb_state_t        w_state;
  logic [NUM_REQ-1:0] w_req;
  logic [NUM_REQ-1:0] w_owner_vec;
  logic               w_owner_req;
  logic               w_others;
  logic               w_expired;
  logic [NUM_REQ-1:0] w_pick_gnt;
  arb_idx_t           w_pick_idx;
  logic [NUM_REQ-1:0] w_gnt_vec;
  arb_idx_t           w_gnt_idx;

  assign w_req       = {r3, r2, r1};
  assign w_state     = (r_owner == OWNER_NONE) ? ST_IDLE : ST_OWNED;
  assign w_owner_vec = (r_owner == OWNER_NONE) ? 3'b000 : (3'b001 << r_owner);
  assign w_owner_req = |(w_req & w_owner_vec);
  assign w_others    = |(w_req & ~w_owner_vec);
  assign w_expired   = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_MAX) && w_others;

  // Search starts just past the last grant, so an expired owner ranks last.
  rr_pick3 u_pick (
    .req   (w_req),
    .start (next_idx(r_ptr)),
    .gnt   (w_pick_gnt),
    .idx   (w_pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner    <= OWNER_NONE;
      r_ptr      <= 2'd2;
      r_hold_cnt <= '0;
    end else begin
      r_owner    <= w_owner_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  always_comb begin
    w_gnt_vec   = w_pick_gnt;
    w_gnt_idx   = w_pick_idx;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold_cnt;

    if (w_state == ST_OWNED && w_owner_req && !w_expired) begin
      w_gnt_vec = w_owner_vec;
      w_gnt_idx = r_owner;
    end

    if (w_gnt_idx == OWNER_NONE) begin
      w_owner_nxt = OWNER_NONE;
      w_hold_nxt  = '0;
    end else if (w_gnt_idx == r_owner) begin
      if (MAX_HOLD != 0 && r_hold_cnt < HOLD_MAX) w_hold_nxt = r_hold_cnt + HOLD_ONE;
    end else begin
      w_owner_nxt = w_gnt_idx;
      w_ptr_nxt   = w_gnt_idx;
      w_hold_nxt  = HOLD_ONE;
    end
  end

  assign g1  = rst ? 1'b0 : w_gnt_vec[0];
  assign g2  = rst ? 1'b0 : w_gnt_vec[1];
  assign g3  = rst ? 1'b0 : w_gnt_vec[2];
  assign gid = rst ? OWNER_NONE : w_gnt_idx;

endmodule

// File: tb/tb_rr_arbiter3.sv
// Scoreboard bench for rr_arbiter3: MAX_HOLD=4 and MAX_HOLD=0 instances share one request stream.
module tb_rr_arbiter3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       r1 = 1'b0;
  logic       r2 = 1'b0;
  logic       r3 = 1'b0;
  logic       a_g1, a_g2, a_g3;
  logic [1:0] a_gid;
  logic       b_g1, b_g2, b_g3;
  logic [1:0] b_gid;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic       rs;
    logic [2:0] req;
    int         exp4;
    int         exp0;
  } exp_t;

  exp_t q[$];

  int m_owner[2];
  int m_last[2];
  int m_held[2];
  int m_max[2] = '{4, 0};
  int wait4[3];

  always #5 clk = ~clk;

  rr_arbiter3 #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .rst(rst), .r1(r1), .r2(r2), .r3(r3),
    .g1(a_g1), .g2(a_g2), .g3(a_g3), .gid(a_gid)
  );

  rr_arbiter3 #(.MAX_HOLD(0)) dut0 (
    .clk(clk), .rst(rst), .r1(r1), .r2(r2), .r3(r3),
    .g1(b_g1), .g2(b_g2), .g3(b_g3), .gid(b_gid)
  );

  assert property (@(posedge clk) disable iff (rst)
    $onehot0({a_g3, a_g2, a_g1}) && (({a_g3, a_g2, a_g1} & ~{r3, r2, r1}) == 3'b000) &&
    (({r3, r2, r1} == 3'b000) == ({a_g3, a_g2, a_g1} == 3'b000)))
  else begin
    mismatched++;
    $display("FAIL safety4 t=%0t r=%b g=%b", $time, {r3, r2, r1}, {a_g3, a_g2, a_g1});
  end

  assert property (@(posedge clk) disable iff (rst)
    $onehot0({b_g3, b_g2, b_g1}) && (({b_g3, b_g2, b_g1} & ~{r3, r2, r1}) == 3'b000) &&
    (({r3, r2, r1} == 3'b000) == ({b_g3, b_g2, b_g1} == 3'b000)))
  else begin
    mismatched++;
    $display("FAIL safety0 t=%0t r=%b g=%b", $time, {r3, r2, r1}, {b_g3, b_g2, b_g1});
  end

  // Reference model: owner/last as plain ints, held counts cycles already granted.
  task automatic model_step(input int w, input logic rs, input logic [2:0] req, output int g);
    int  c;
    bit  others;
    g = 3;
    if (rs) begin
      m_owner[w] = -1;
      m_last[w]  = 2;
      m_held[w]  = 0;
      return;
    end
    others = 0;
    for (int i = 0; i < 3; i++) if (i != m_owner[w] && req[i]) others = 1;
    if (m_owner[w] >= 0 && req[m_owner[w]] &&
        !(m_max[w] != 0 && m_held[w] >= m_max[w] && others)) begin
      g = m_owner[w];
    end else begin
      for (int k = 1; k <= 3; k++) begin
        c = (m_last[w] + k) % 3;
        if (req[c]) begin
          g = c;
          break;
        end
      end
    end
    if (g == 3) begin
      m_owner[w] = -1;
      m_held[w]  = 0;
    end else if (g == m_owner[w]) begin
      m_held[w]++;
    end else begin
      m_owner[w] = g;
      m_last[w]  = g;
      m_held[w]  = 1;
    end
  endtask

  // d4/d0 >= 0 gives an explicit expected gid; -1 takes the model's answer.
  task automatic step(input logic rs, input logic [2:0] req, input int d4, input int d0);
    exp_t e;
    int   m4, m0;
    @(posedge clk);
    #1;
    rst = rs;
    {r3, r2, r1} = req;
    model_step(0, rs, req, m4);
    model_step(1, rs, req, m0);
    e.rs   = rs;
    e.req  = req;
    e.exp4 = (d4 >= 0) ? d4 : m4;
    e.exp0 = (d0 >= 0) ? d0 : m0;
    q.push_back(e);
  endtask

  function automatic void check(input string nm, input logic [2:0] g, input logic [1:0] gi,
                                input int exp);
    logic [2:0] ev;
    logic [1:0] ei;
    ei = exp[1:0];
    ev = (exp == 3) ? 3'b000 : (3'b001 << exp);
    compared++;
    if (g !== ev || gi !== ei) begin
      mismatched++;
      $display("FAIL %s t=%0t got g=%b gid=%0d want g=%b gid=%0d", nm, $time, g, gi, ev, ei);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("grant_mh4", {a_g3, a_g2, a_g1}, a_gid, e.exp4);
      check("grant_mh0", {b_g3, b_g2, b_g1}, b_gid, e.exp0);
      for (int i = 0; i < 3; i++) begin
        if (e.rs || !e.req[i] || (a_gid == 2'(i))) begin
          wait4[i] = 0;
        end else begin
          wait4[i]++;
          compared++;
          if (wait4[i] > 8) begin
            mismatched++;
            $display("FAIL wait_bound t=%0t req%0d waited=%0d limit=8", $time, i + 1, wait4[i]);
          end
        end
      end
    end
  end

  task automatic do_reset();
    for (int i = 0; i < 2; i++) step(1'b1, 3'b000, 3, 3);
  endtask

  initial begin
    logic [2:0] rq;
    logic       rs;
    int         budget;

    do_reset();

    // All three requesting: rotate every 4 cycles with MAX_HOLD=4, never with 0.
    for (int i = 0; i < 14; i++) step(1'b0, 3'b111, (i / 4) % 3, 0);

    // Owner drop: r1 falls while r3 is up, handoff in the same cycle.
    do_reset();
    step(1'b0, 3'b001, 0, 0);
    step(1'b0, 3'b001, 0, 0);
    step(1'b0, 3'b100, 2, 2);
    step(1'b0, 3'b100, 2, 2);

    // Sole requester keeps the grant; saturated counter expires as soon as r1 joins.
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b0, 3'b010, 1, 1);
    step(1'b0, 3'b011, 0, 1);
    for (int i = 0; i < 6; i++) step(1'b0, 3'b011, -1, 1);

    // Unlimited hold: r1 keeps the grant for 50 cycles, r2 takes over on release.
    do_reset();
    for (int i = 0; i < 50; i++) step(1'b0, 3'b011, -1, 0);
    step(1'b0, 3'b010, 1, 1);

    // Reset in the middle of ownership of r3.
    do_reset();
    step(1'b0, 3'b100, 2, 2);
    step(1'b0, 3'b110, 2, 2);
    step(1'b1, 3'b110, 3, 3);
    step(1'b0, 3'b110, 1, 1);

    // Random traffic with sticky requests and occasional resets.
    rq = 3'b000;
    for (int i = 0; i < 10000; i++) begin
      for (int b = 0; b < 3; b++) if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
      rs = ($urandom_range(0, 299) == 0);
      step(rs, rq, -1, -1);
    end

    budget = 0;
    while (q.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    if (q.size() > 0) begin
      mismatched++;
      $display("FAIL drain pending=%0d want 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rr_arbiter3.md
# rr_arbiter3

Three-requester round-robin arbiter that produces the grant vector `g1..g3` from the request vector `r1..r3`. It is the implementation side of the team's three-way arbiter safety predicate and must satisfy that predicate on every non-reset cycle:

- at most one grant;
- a grant only to an active requester;
- no grant only when no requests are active.

Ownership is sticky while the owner keeps requesting, with an optional bounded-hold preemption for fairness.

## Interface
- `MAX_HOLD`, default 4: max consecutive cycles one owner may keep the grant while another requester waits; 0 = unlimited (no preemption).
- `clk` input 1: single clock, all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `r1`, `r2`, `r3` input 1 each: request lines, level-sensitive.
- `g1`, `g2`, `g3` output 1 each: grant lines, combinational from current requests and registered state, one-hot or zero.
- `gid` output 2: index of current grant (0, 1, 2), 3 = none.

## Operation
- **Registered state**
  - `owner` (2b): 0..2, or 3 = none.
  - `ptr` (2b): index last granted; the round-robin search starts at `ptr+1` mod 3.
  - `hold_cnt`: width `$clog2(MAX_HOLD+1)`, minimum 1.
- **Effective FSM states**
  - IDLE: `owner`=3.
  - OWNED: `owner`=k.
- **Combinational grant selection each cycle**
  - If OWNED, `r[owner]`=1, and not expired → grant `owner`.
  - Expired means `MAX_HOLD`≠0, `hold_cnt`==`MAX_HOLD`, and some other `r` is 1.
  - Otherwise grant the first active request in order `ptr+1`, `ptr+2`, `ptr` (mod 3).
  - If there are no requests → no grant, `gid`=3.
- **Next state at clock edge**
  - Grant to same owner → `hold_cnt`+1, saturating at `MAX_HOLD`.
  - Grant to new index j → `owner`=j, `ptr`=j, `hold_cnt`=1.
  - No grant → `owner`=3, `hold_cnt`=0; `ptr` unchanged.
- **Owner request drop**: release is same-cycle. Another requester is granted in that cycle with no idle bubble.
- **Sole requester**: an expired owner that is still the only requester keeps the grant; the counter stays saturated.
- **Simultaneous events**: the owner drops while two others rise → rotate from `ptr+1`. Requests rising in the same cycle as preemption → the rotate search includes them.
- **Reset**
  - While `rst`=1: `g1..g3` forced 0, `gid`=3; the safety predicate is excused.
  - At the edge: `owner`=3, `ptr`=2 (so first priority order is r1, r2, r3), `hold_cnt`=0.
  - Reset mid-ownership discards ownership. The first post-reset cycle arbitrates fresh.

## Timing
- Grant latency from request: 0 cycles (combinational path `r` → `g`). Any downstream register adds its own cycle.
- Release latency: 0 cycles.
- Preemption occurs in the cycle after the owner has held `MAX_HOLD` cycles with a competitor waiting. Worst-case wait for a continuously requesting input is 2·`MAX_HOLD` cycles.
- No input registering. `r*` must be synchronous to `clk`.

## Structure
- Package `arb_pkg`:
  - `OWNER_NONE` = 2'd3;
  - `NUM_REQ` = 3;
  - typedef `arb_idx_t` (logic [1:0]).
- Sub-module `rr_pick3`: purely combinational. Inputs `req[2:0]` and `start` (0..2). Outputs `gnt[2:0]` (one-hot or zero) and `idx`. The top level instantiates it once for the rotate search.
- The top level holds the registers, the sticky/expiry logic, and output forcing under reset.
- The bench embeds the safety predicate as a concurrent assertion, disabled while `rst`.

## Test plan
- Reset release with r=(1,1,1) → g=(1,0,0), `gid`=0 on the first cycle. Hold r steady, `MAX_HOLD`=4 → g1 for 4 cycles, then g2 for 4, then g3, then g1.
- Owner drop: g1 owned, r1 falls while r3=1 and r2=0 → g3 in the same cycle, `gid`=2, no zero-grant cycle.
- Sole requester: only r2=1 for 20 cycles, `MAX_HOLD`=4 → g2 held for all 20 cycles; `hold_cnt` saturates at 4.
- `MAX_HOLD`=0: r1 held for 50 cycles with r2=1 → g1 for all 50 cycles; r1 falls → g2 the same cycle.
- Mid-ownership reset: g3 owned (`ptr`=2), `rst` pulsed 1 cycle with r=(0,1,1) → g=0 during reset, then g2 after reset.
- Random requests for 10k cycles with random resets → the safety predicate always holds outside reset, and no requester waits more than 2·`MAX_HOLD` cycles.
